// File: rtl/mul_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mul_pkg
//  Description : Shared types and constants for the multiply/HI-LO sequencer.
//  Revision    : 1.0 - initial release
// ============================================================================
package mul_pkg;

  // Sequencer state: waiting for a request, or holding operands while the
  // combinational multiplier settles.
  typedef enum logic {
    IDLE = 1'b0,
    CALC = 1'b1
  } state_e;

  // Default operand / HI / LO width; the product is twice this wide.
  localparam int DEF_DATA_W = 32;

  // Settle counter width; covers hold times of 1..15 clocks.
  localparam int MUL_CNT_W = 4;

endpackage : mul_pkg
`default_nettype wire

// File: rtl/hilo_reg_pair.sv
`default_nettype none
// ============================================================================
//  Module      : hilo_reg_pair
//  Description : Architectural HI/LO registers. A product capture loads both
//                words and wins over the mthi/mtlo write enables.
//  Revision    : 1.0 - initial release
// ============================================================================
module hilo_reg_pair
  import mul_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic              clock,
  input  logic              clear,
  input  logic              capture,
  input  logic [DATA_W-1:0] cap_hi,
  input  logic [DATA_W-1:0] cap_lo,
  input  logic              hi_we,
  input  logic [DATA_W-1:0] hi_in,
  input  logic              lo_we,
  input  logic [DATA_W-1:0] lo_in,
  output logic [DATA_W-1:0] hi_out,
  output logic [DATA_W-1:0] lo_out
);

  logic [DATA_W-1:0] r_hi;
  logic [DATA_W-1:0] r_lo;

  // HI/LO update: product capture first, otherwise the individual moves.
  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      r_hi <= '0;
      r_lo <= '0;
    end else if (capture) begin
      r_hi <= cap_hi;
      r_lo <= cap_lo;
    end else begin
      if (hi_we) r_hi <= hi_in;
      if (lo_we) r_lo <= lo_in;
    end
  end

  assign hi_out = r_hi;
  assign lo_out = r_lo;

endmodule : hilo_reg_pair
`default_nettype wire

// File: rtl/mul_hilo_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : mul_hilo_ctrl
//  Description : Sequencer around an external combinational signed multiplier.
//                Latches operands, holds them MUL_CYCLES clocks while the
//                multiplier settles, then captures the product into HI/LO.
//  Revision    : 1.0 - initial release
// ============================================================================
module mul_hilo_ctrl
  import mul_pkg::*;
#(
  parameter int DATA_W     = DEF_DATA_W,
  parameter int MUL_CYCLES = 2
) (
  input  logic              clock,
  input  logic              clear,
  input  logic              start,
  input  logic [DATA_W-1:0] op_a,
  input  logic [DATA_W-1:0] op_b,
  output logic [DATA_W-1:0] mul_a,
  output logic [DATA_W-1:0] mul_b,
  input  logic [DATA_W-1:0] mul_lo,
  input  logic [DATA_W-1:0] mul_hi,
  input  logic              hi_we,
  input  logic [DATA_W-1:0] hi_in,
  input  logic              lo_we,
  input  logic [DATA_W-1:0] lo_in,
  output logic [DATA_W-1:0] hi_out,
  output logic [DATA_W-1:0] lo_out,
  output logic              busy,
  output logic              done
);

  // Counter preload: the last CALC cycle is the one where the count is zero.
  localparam logic [MUL_CNT_W-1:0] C_CNT_LOAD = MUL_CNT_W'(MUL_CYCLES - 1);

  state_e                 r_state;
  state_e                 w_state_next;
  logic [MUL_CNT_W-1:0]   r_cnt;
  logic [MUL_CNT_W-1:0]   w_cnt_next;
  logic [DATA_W-1:0]      r_mul_a;
  logic [DATA_W-1:0]      r_mul_b;
  logic                   r_done;
  logic                   w_accept;
  logic                   w_capture;
  logic                   w_idle;

  // Next-state, counter and accept/capture decode.
  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_accept     = 1'b0;
    w_capture    = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_accept     = 1'b1;
          w_cnt_next   = C_CNT_LOAD;
          w_state_next = CALC;
        end
      end
      CALC: begin
        if (r_cnt != '0) begin
          w_cnt_next = r_cnt - MUL_CNT_W'(1);
        end else begin
          w_capture    = 1'b1;
          w_state_next = IDLE;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  // State, counter and done-pulse registers.
  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
      r_done  <= w_capture;
    end
  end

  // Operand latches feeding the multiplier; they move only on an accepted
  // start so the multiplier inputs stay stable through CALC and IDLE.
  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      r_mul_a <= '0;
      r_mul_b <= '0;
    end else if (w_accept) begin
      r_mul_a <= op_a;
      r_mul_b <= op_b;
    end
  end

  // mthi/mtlo only act while no multiply is in flight.
  assign w_idle = (r_state == IDLE);

  hilo_reg_pair #(
    .DATA_W (DATA_W)
  ) u_hilo (
    .clock   (clock),
    .clear   (clear),
    .capture (w_capture),
    .cap_hi  (mul_hi),
    .cap_lo  (mul_lo),
    .hi_we   (hi_we & w_idle),
    .hi_in   (hi_in),
    .lo_we   (lo_we & w_idle),
    .lo_in   (lo_in),
    .hi_out  (hi_out),
    .lo_out  (lo_out)
  );

  assign mul_a = r_mul_a;
  assign mul_b = r_mul_b;
  assign busy  = (r_state == CALC);
  assign done  = r_done;

endmodule : mul_hilo_ctrl
`default_nettype wire

// File: tb/tb_mul_hilo_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mul_hilo_ctrl
//  Description : Self-checking bench for mul_hilo_ctrl with a behavioural
//                stand-in for the Booth multiplier (MUL_CYCLES=2 and 1).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mul_hilo_ctrl;

  localparam int DW = 32;
  localparam int MC = 2;

  logic          clock;
  logic          clear;
  logic          start;
  logic [DW-1:0] op_a, op_b, mul_a, mul_b, mul_lo, mul_hi;
  logic          hi_we, lo_we;
  logic [DW-1:0] hi_in, lo_in, hi_out, lo_out;
  logic          busy, done;

  logic          start_1;
  logic [DW-1:0] op_a_1, op_b_1, mul_a_1, mul_b_1, mul_lo_1, mul_hi_1;
  logic          hi_we_1, lo_we_1;
  logic [DW-1:0] hi_in_1, lo_in_1, hi_out_1, lo_out_1;
  logic          busy_1, done_1;

  int checks = 0;
  int errors = 0;

  // Reference: full-width signed product.
  function automatic logic [63:0] ref_prod(input logic [DW-1:0] a, input logic [DW-1:0] b);
    longint sa, sb;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    return 64'(sa * sb);
  endfunction

  // Stand-in for the combinational Booth multiplier next to each DUT.
  assign {mul_hi, mul_lo}     = ref_prod(mul_a, mul_b);
  assign {mul_hi_1, mul_lo_1} = ref_prod(mul_a_1, mul_b_1);

  mul_hilo_ctrl #(.DATA_W(DW), .MUL_CYCLES(MC)) dut (
    .clock(clock), .clear(clear), .start(start), .op_a(op_a), .op_b(op_b),
    .mul_a(mul_a), .mul_b(mul_b), .mul_lo(mul_lo), .mul_hi(mul_hi),
    .hi_we(hi_we), .hi_in(hi_in), .lo_we(lo_we), .lo_in(lo_in),
    .hi_out(hi_out), .lo_out(lo_out), .busy(busy), .done(done)
  );

  mul_hilo_ctrl #(.DATA_W(DW), .MUL_CYCLES(1)) dut1 (
    .clock(clock), .clear(clear), .start(start_1), .op_a(op_a_1), .op_b(op_b_1),
    .mul_a(mul_a_1), .mul_b(mul_b_1), .mul_lo(mul_lo_1), .mul_hi(mul_hi_1),
    .hi_we(hi_we_1), .hi_in(hi_in_1), .lo_we(lo_we_1), .lo_in(lo_in_1),
    .hi_out(hi_out_1), .lo_out(lo_out_1), .busy(busy_1), .done(done_1)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Run one multiply on the MC=2 instance and check the cycle-by-cycle timing.
  // With b2b set, the call starts at the negedge of the previous done cycle.
  task automatic do_mul(input logic [DW-1:0] a, input logic [DW-1:0] b, input bit b2b);
    logic [63:0] p;
    p = ref_prod(a, b);
    if (!b2b) begin
      @(posedge clock); #1;
    end
    start = 1'b1; op_a = a; op_b = b;
    if (!b2b) begin
      @(negedge clock);
      checks++;
      if (busy !== 1'b0 || done !== 1'b0) begin
        errors++; $display("FAIL c0_idle: busy=%b done=%b required busy=0 done=0", busy, done);
      end
    end
    for (int k = 1; k <= MC + 1; k++) begin
      @(posedge clock); #1;
      start = 1'b0;
      @(negedge clock);
      checks++;
      if (busy !== (k <= MC)) begin
        errors++; $display("FAIL busy_c%0d: busy=%b required %b", k, busy, (k <= MC));
      end
      checks++;
      if (done !== (k == MC + 1)) begin
        errors++; $display("FAIL done_c%0d: done=%b required %b", k, done, (k == MC + 1));
      end
      if (k == 1) begin
        checks++;
        if (mul_a !== a || mul_b !== b) begin
          errors++; $display("FAIL operands: mul_a=%h mul_b=%h required %h %h", mul_a, mul_b, a, b);
        end
      end
    end
    checks++;
    if (hi_out !== p[63:32] || lo_out !== p[31:0]) begin
      errors++; $display("FAIL product %h*%h: hi=%h lo=%h required %h %h", a, b, hi_out, lo_out, p[63:32], p[31:0]);
    end
  endtask

  task automatic test_reset();
    clear = 1'b1;
    repeat (2) @(posedge clock);
    @(negedge clock);
    checks++;
    if ({hi_out, lo_out, mul_a, mul_b} !== '0 || busy !== 1'b0 || done !== 1'b0) begin
      errors++; $display("FAIL reset: hi=%h lo=%h a=%h b=%h busy=%b done=%b required all 0",
                         hi_out, lo_out, mul_a, mul_b, busy, done);
    end
    checks++;
    if ({hi_out_1, lo_out_1, mul_a_1, mul_b_1} !== '0 || busy_1 !== 1'b0 || done_1 !== 1'b0) begin
      errors++; $display("FAIL reset_mc1: hi=%h lo=%h busy=%b done=%b required all 0",
                         hi_out_1, lo_out_1, busy_1, done_1);
    end
    clear = 1'b0;
  endtask

  task automatic test_basic();
    do_mul(32'd7, 32'hFFFF_FFFD, 1'b0);
    checks++;
    if (hi_out !== 32'hFFFF_FFFF || lo_out !== 32'hFFFF_FFEB) begin
      errors++; $display("FAIL basic_const: hi=%h lo=%h required ffffffff ffffffeb", hi_out, lo_out);
    end
  endtask

  task automatic test_back_to_back();
    do_mul(32'h8000_0000, 32'h8000_0000, 1'b0);
    checks++;
    if (hi_out !== 32'h4000_0000 || lo_out !== 32'h0) begin
      errors++; $display("FAIL minmin: hi=%h lo=%h required 40000000 00000000", hi_out, lo_out);
    end
    do_mul(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
    checks++;
    if (hi_out !== 32'h0 || lo_out !== 32'h1) begin
      errors++; $display("FAIL neg1sq: hi=%h lo=%h required 0 1", hi_out, lo_out);
    end
  endtask

  task automatic test_start_ignored();
    logic [63:0] p;
    p = ref_prod(32'd7, 32'hFFFF_FFFD);
    @(posedge clock); #1;
    start = 1'b1; op_a = 32'd7; op_b = 32'hFFFF_FFFD;
    @(posedge clock); #1;
    op_a = 32'd5; op_b = 32'd5;
    for (int k = 1; k <= 2; k++) begin
      @(negedge clock);
      checks++;
      if (mul_a !== 32'd7 || mul_b !== 32'hFFFF_FFFD || busy !== 1'b1) begin
        errors++; $display("FAIL ignore_c%0d: mul_a=%h mul_b=%h busy=%b required 7 fffffffd 1", k, mul_a, mul_b, busy);
      end
      @(posedge clock); #1;
      start = 1'b0;
    end
    @(negedge clock);
    checks++;
    if (done !== 1'b1 || hi_out !== p[63:32] || lo_out !== p[31:0]) begin
      errors++; $display("FAIL ignore_result: done=%b hi=%h lo=%h required 1 %h %h", done, hi_out, lo_out, p[63:32], p[31:0]);
    end
    @(posedge clock);
    @(negedge clock);
    checks++;
    if (busy !== 1'b0 || mul_a !== 32'd7) begin
      errors++; $display("FAIL ignore_after: busy=%b mul_a=%h required 0 7", busy, mul_a);
    end
  endtask

  task automatic test_clear_abort();
    @(posedge clock); #1;
    start = 1'b1; op_a = 32'd9; op_b = 32'd9;
    @(posedge clock); #1;
    start = 1'b0;
    clear = 1'b1;
    #1;
    checks++;
    if (hi_out !== '0 || lo_out !== '0 || busy !== 1'b0 || done !== 1'b0) begin
      errors++; $display("FAIL abort: hi=%h lo=%h busy=%b done=%b required 0 0 0 0", hi_out, lo_out, busy, done);
    end
    #1 clear = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clock);
      checks++;
      if (done !== 1'b0 || busy !== 1'b0) begin
        errors++; $display("FAIL abort_nodone_%0d: done=%b busy=%b required 0 0", k, done, busy);
      end
      @(posedge clock);
    end
  endtask

  task automatic test_mthi_mtlo();
    logic [DW-1:0] a, b;
    logic [63:0]   p;
    a = $urandom; b = $urandom;
    p = ref_prod(a, b);
    @(posedge clock); #1;
    hi_we = 1'b1; hi_in = 32'hDEAD_BEEF; lo_we = 1'b1; lo_in = 32'h1234_5678;
    @(posedge clock); #1;
    hi_we = 1'b0; lo_we = 1'b0;
    @(negedge clock);
    checks++;
    if (hi_out !== 32'hDEAD_BEEF || lo_out !== 32'h1234_5678) begin
      errors++; $display("FAIL mthi_mtlo: hi=%h lo=%h required deadbeef 12345678", hi_out, lo_out);
    end
    // start and mthi together: both act, capture later overwrites
    @(posedge clock); #1;
    start = 1'b1; op_a = a; op_b = b; hi_we = 1'b1; hi_in = 32'hCAFE_F00D;
    @(posedge clock); #1;
    start = 1'b0; hi_we = 1'b0; lo_we = 1'b1; lo_in = 32'hAAAA_5555;
    @(negedge clock);
    checks++;
    if (hi_out !== 32'hCAFE_F00D || lo_out !== 32'h1234_5678) begin
      errors++; $display("FAIL start_mthi_c1: hi=%h lo=%h required cafef00d 12345678", hi_out, lo_out);
    end
    @(posedge clock); #1;
    lo_we = 1'b0;
    @(negedge clock);
    checks++;
    if (lo_out !== 32'h1234_5678) begin
      errors++; $display("FAIL mtlo_in_calc: lo=%h required 12345678", lo_out);
    end
    @(posedge clock);
    @(negedge clock);
    checks++;
    if (done !== 1'b1 || hi_out !== p[63:32] || lo_out !== p[31:0]) begin
      errors++; $display("FAIL capture_over_mt: done=%b hi=%h lo=%h required 1 %h %h", done, hi_out, lo_out, p[63:32], p[31:0]);
    end
  endtask

  task automatic test_random();
    logic [DW-1:0] a, b;
    bit            b2b;
    for (int i = 0; i < 20; i++) begin
      case (i % 5)
        0:       begin a = 32'h7FFF_FFFF; b = $urandom; end
        1:       begin a = $urandom; b = 32'h8000_0000; end
        default: begin a = $urandom; b = $urandom; end
      endcase
      b2b = (i > 0) && ($urandom_range(0, 1) == 1);
      do_mul(a, b, b2b);
    end
  endtask

  task automatic test_mul_cycles_one();
    logic [DW-1:0] a, b;
    logic [63:0]   p;
    for (int i = 0; i < 4; i++) begin
      if (i == 0) begin a = 32'd3; b = 32'd4; end
      else begin a = $urandom; b = $urandom; end
      p = ref_prod(a, b);
      @(posedge clock); #1;
      start_1 = 1'b1; op_a_1 = a; op_b_1 = b;
      @(posedge clock); #1;
      start_1 = 1'b0;
      @(negedge clock);
      checks++;
      if (busy_1 !== 1'b1 || done_1 !== 1'b0) begin
        errors++; $display("FAIL mc1_c1: busy=%b done=%b required 1 0", busy_1, done_1);
      end
      @(posedge clock);
      @(negedge clock);
      checks++;
      if (busy_1 !== 1'b0 || done_1 !== 1'b1 || hi_out_1 !== p[63:32] || lo_out_1 !== p[31:0]) begin
        errors++; $display("FAIL mc1_c2: busy=%b done=%b hi=%h lo=%h required 0 1 %h %h",
                           busy_1, done_1, hi_out_1, lo_out_1, p[63:32], p[31:0]);
      end
    end
  endtask

  initial begin
    clear = 1'b1; start = 1'b0; op_a = '0; op_b = '0;
    hi_we = 1'b0; lo_we = 1'b0; hi_in = '0; lo_in = '0;
    start_1 = 1'b0; op_a_1 = '0; op_b_1 = '0;
    hi_we_1 = 1'b0; lo_we_1 = 1'b0; hi_in_1 = '0; lo_in_1 = '0;
    test_reset();
    test_basic();
    test_back_to_back();
    test_start_ignored();
    test_clear_abort();
    test_mthi_mtlo();
    test_random();
    test_mul_cycles_one();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule : tb_mul_hilo_ctrl
`default_nettype wire
